alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port: req_valid  input  1  request present.
REQ-005 SHALL have port: req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have ports: req_op  input  5, req_a  input  WIDTH, req_b  input  WIDTH, req_tag  input  4 (operation, operands, caller tag).
REQ-007 SHALL have ports: alu_in1  output  WIDTH, alu_in2  output  WIDTH, opcode  output  5 (drive ALU).
REQ-008 SHALL have ports: alu_result  input  WIDTH, alu_flag  input  1 (ALU outputs).
REQ-009 SHALL have ports: rsp_valid  output  1, rsp_ready  input  1 (response handshake).
REQ-010 SHALL have ports: rsp_result  output  WIDTH, rsp_flag  output  1, rsp_err  output  1, rsp_tag  output  4.
REQ-011 SHALL have port: op_count  output  16  count of completed responses.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, RESP; IDLE after reset.
REQ-013 SHALL assert req_ready only in IDLE; the handshake is req_valid && req_ready on a rising edge.
REQ-014 On acceptance, SHALL register req_op/req_a/req_b/req_tag into alu_in1/alu_in2/opcode/tag registers and go to ISSUE (or RESP directly on error, REQ-017/018).
REQ-015 In ISSUE (exactly one cycle), SHALL capture alu_result into rsp_result and go to RESP; rsp_valid high the cycle after ISSUE (latency: accept edge N, rsp_valid from cycle N+2).
REQ-016 SHALL pass rsp_flag = alu_flag only for opcodes 00000 (eq), 01000 (neq), 01011 (slt), 01100 (sltu); rsp_flag SHALL be 0 for all other opcodes.
REQ-017 Illegal opcode (req_op >= 5'b01111): SHALL not issue; go IDLE->RESP; rsp_err=1, rsp_result=0, rsp_flag=0; opcode/alu_in outputs unchanged.
REQ-018 Divide (00011) with req_b==0: SHALL not issue; rsp_err=1, rsp_result all-ones, rsp_flag=0.
REQ-019 rsp_err SHALL be 0 for all other accepted requests.
REQ-020 In RESP, rsp_valid=1; rsp_result/rsp_flag/rsp_err/rsp_tag SHALL stay stable while rsp_ready=0.
REQ-021 On rsp_valid && rsp_ready, SHALL return to IDLE, drop rsp_valid next cycle, and increment op_count (errored responses included).
REQ-022 op_count SHALL wrap 16'hFFFF -> 16'h0000 silently.
REQ-023 No new request SHALL be accepted in the cycle the response handshakes (req_ready rises the following cycle); max throughput one op per 3 cycles.
REQ-024 alu_in1/alu_in2/opcode SHALL hold their last issued values while IDLE and RESP (never X/Z after reset).
REQ-025 req_* inputs SHALL be ignored when req_ready=0.

Reset
REQ-026 On rst high, SHALL asynchronously force: state IDLE, req_ready=1 once rst low, rsp_valid=0, rsp_result=0, rsp_flag=0, rsp_err=0, rsp_tag=0, alu_in1=0, alu_in2=0, opcode=0, op_count=0.
REQ-027 Reset mid-operation (ISSUE or RESP) SHALL discard the pending response with no op_count increment.

Verification
REQ-028 Add: op=00000, a=5, b=5, tag=3, rsp_ready=1 -> rsp_valid at N+2, rsp_result=10, rsp_flag=1, rsp_err=0, rsp_tag=3, op_count=1.
REQ-029 Backpressure: op=00010, a=7, b=6, rsp_ready=0 for 4 cycles -> rsp_result=42 stable, req_ready=0 throughout; on rsp_ready=1 one handshake, op_count increments once.
REQ-030 Errors: op=00011, b=0 -> rsp_err=1, rsp_result=FFFFFFFF, opcode output unchanged; op=10000 -> rsp_err=1, rsp_result=0, rsp_valid at N+1.
REQ-031 Flag masking: op=00100 (and) with ALU model driving alu_flag=1 -> rsp_flag=0; op=01011, a=-1, b=1 -> rsp_result=1, rsp_flag=1.
REQ-032 Reset in RESP with rsp_ready=0 -> rsp_valid=0 immediately, op_count=0, req_ready=1 after rst release.
REQ-033 Wrap: 65536 back-to-back completed ops -> op_count returns to 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-outstanding issue controller for a combinational ALU.
// It accepts one request and drives the ALU operand/opcode registers. It
// captures the ALU result one cycle later and holds the response until the
// consumer takes it. Illegal opcodes and divide-by-zero are answered directly
// with an error response, and the ALU is never driven for them.
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_tag,
  // ALU drive
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [4:0]       opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic [3:0]       rsp_tag,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [4:0] OP_DIV         = 5'b00011;
  localparam logic [4:0] OP_ILLEGAL_MIN = 5'b01111;

  state_t           state_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_flag_q;
  logic             rsp_err_q;
  logic [3:0]       tag_q;
  logic [WIDTH-1:0] alu_in1_q;
  logic [WIDTH-1:0] alu_in2_q;
  logic [4:0]       opcode_q;
  logic [15:0]      op_count_q;

  logic accept;
  logic req_illegal;
  logic req_div_zero;

  // Only the compare operations produce a meaningful flag. For all others the flag is masked.
  function automatic logic is_flag_op(input logic [4:0] op);
    return (op == 5'b00000) || (op == 5'b01000) ||
           (op == 5'b01011) || (op == 5'b01100);
  endfunction

  // Request decode. The request is only looked at while the controller is ready.
  // NOTE: continuous assigns and always_comb with full defaults cannot infer
  // latches; every combinational output here is assigned on every path.
  assign accept       = req_valid && req_ready_q;
  assign req_illegal  = (req_op >= OP_ILLEGAL_MIN);
  assign req_div_zero = (req_op == OP_DIV) && (req_b == '0);

  // Issue FSM with registered outputs. Error requests skip ISSUE and leave the ALU drive untouched.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      tag_q        <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      opcode_q     <= '0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q       <= req_tag;
            req_ready_q <= 1'b0;
            if (req_illegal) begin
              rsp_result_q <= '0;
              rsp_flag_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end else if (req_div_zero) begin
              rsp_result_q <= '1;
              rsp_flag_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end else begin
              alu_in1_q <= req_a;
              alu_in2_q <= req_b;
              opcode_q  <= req_op;
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          rsp_result_q <= alu_result;
          rsp_flag_q   <= is_flag_op(opcode_q) && alu_flag;
          rsp_err_q    <= 1'b0;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tag    = tag_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign opcode     = opcode_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl. A behavioural ALU is attached to the DUT's ALU
// ports. Responses are predicted from the request alone: ALU arithmetic on the
// request operands, the flag mask, the error rules and a completed-op counter.
module tb_alu_issue_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [W-1:0]  req_a, req_b;
  logic [3:0]    req_tag;
  logic [W-1:0]  alu_in1, alu_in2;
  logic [4:0]    opcode;
  logic [W-1:0]  alu_result;
  logic          alu_flag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_flag, rsp_err;
  logic [3:0]    rsp_tag;
  logic [15:0]   op_count;

  int            n_tests = 0;
  int            n_fail  = 0;

  // reference state
  logic [15:0]   model_count;
  logic [W-1:0]  last_a, last_b;
  logic [4:0]    last_op;
  logic [W-1:0]  exp_res;
  logic          exp_flag, exp_err;
  logic [3:0]    exp_tag;

  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .opcode     (opcode),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {flag, result}. Non-compare ops raise the flag so that masking is visible.
  function automatic logic [W:0] alu_model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         f;
    f = 1'b1;
    case (op)
      5'd0:  begin r = a + b; f = (a == b); end
      5'd1:  r = a - b;
      5'd2:  r = a * b;
      5'd3:  r = (b == '0) ? '1 : a / b;
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7:  r = a << b[4:0];
      5'd8:  begin r = a - b; f = (a != b); end
      5'd9:  r = a >> b[4:0];
      5'd10: r = $unsigned($signed(a) >>> b[4:0]);
      5'd11: begin f = ($signed(a) < $signed(b)); r = {{(W-1){1'b0}}, f}; end
      5'd12: begin f = (a < b); r = {{(W-1){1'b0}}, f}; end
      5'd13: r = ~a;
      5'd14: r = a;
      default: r = '0;
    endcase
    return {f, r};
  endfunction

  always_comb {alu_flag, alu_result} = alu_model(opcode, alu_in1, alu_in2);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_rsp();
    check("rsp_valid",  rsp_valid,  1);
    check("rsp_result", rsp_result, exp_res);
    check("rsp_flag",   rsp_flag,   exp_flag);
    check("rsp_err",    rsp_err,    exp_err);
    check("rsp_tag",    rsp_tag,    exp_tag);
    check("req_ready_resp", req_ready, 0);
    check("alu_in1_hold", alu_in1, last_a);
    check("alu_in2_hold", alu_in2, last_b);
    check("opcode_hold",  opcode,  last_op);
  endtask

  // Present one request, wait for the response, check latency and contents. Leaves the DUT in RESP.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] tag);
    logic       illegal, div0;
    logic [W:0] m;
    int         waitc;
    int         lat;
    illegal = (op >= 5'd15);
    div0    = (op == 5'd3) && (b == '0);
    exp_err = illegal || div0;
    exp_tag = tag;
    if (illegal) begin
      exp_res = '0; exp_flag = 1'b0;
    end else if (div0) begin
      exp_res = '1; exp_flag = 1'b0;
    end else begin
      m        = alu_model(op, a, b);
      exp_res  = m[W-1:0];
      exp_flag = m[W] && (op inside {5'd0, 5'd8, 5'd11, 5'd12});
    end
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 5'($urandom); req_a = $urandom; req_b = $urandom; req_tag = 4'($urandom);
    if (!exp_err) begin
      last_a = a; last_b = b; last_op = op;
    end
    check("alu_in1", alu_in1, last_a);
    check("alu_in2", alu_in2, last_b);
    check("opcode",  opcode,  last_op);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      check("req_ready_busy", req_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_err ? 1 : 2);
    check_rsp();
  endtask

  // Hold off the response for bp cycles while waving junk requests, then handshake once.
  task automatic complete(input int bp);
    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'($urandom);
      req_op = 5'($urandom); req_a = $urandom; req_b = $urandom; req_tag = 4'($urandom);
      @(negedge clk);
      check_rsp();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready   = 1'b0;
    model_count = model_count + 16'd1;
    check("rsp_valid_drop", rsp_valid, 0);
    check("op_count", op_count, model_count);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    logic [4:0]   op;
    logic [W-1:0] a, b;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    model_count = '0; last_a = '0; last_b = '0; last_op = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flag", rsp_flag, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_alu", {alu_in1, alu_in2, opcode}, 0);
    check("rst_op_count", op_count, 0);

    // add with equal operands: flag passes, single-cycle issue
    issue(5'b00000, 32'd5, 32'd5, 4'd3); complete(0);
    // multiply under backpressure
    issue(5'b00010, 32'd7, 32'd6, 4'd9); complete(4);
    // divide by zero, then illegal opcode: ALU drive must not move
    issue(5'b00011, 32'd100, 32'd0, 4'd1); complete(1);
    issue(5'b10000, 32'd11, 32'd12, 4'd2); complete(2);
    issue(5'b01111, 32'd1, 32'd2, 4'd4); complete(0);
    // flag masking and signed compare
    issue(5'b00100, 32'hF0F0, 32'h0FF0, 4'd5); complete(0);
    issue(5'b01011, 32'hFFFF_FFFF, 32'd1, 4'd6); complete(0);
    issue(5'b01100, 32'hFFFF_FFFF, 32'd1, 4'd7); complete(0);
    issue(5'b00011, 32'd100, 32'd7, 4'd8); complete(0);

    // reset while holding a response
    issue(5'b00010, 32'd3, 32'd4, 4'd10);
    #2 rst = 1'b1;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_alu_in1", alu_in1, 0);
    @(negedge clk);
    rst = 1'b0;
    model_count = '0; last_a = '0; last_b = '0; last_op = '0;
    @(negedge clk);
    check("postrst_req_ready", req_ready, 1);
    check("postrst_op_count", op_count, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 14));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? a : $urandom);
      issue(op, a, b, 4'($urandom));
      complete($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
